// File: rtl/gpu_pkg.sv
// Shared types and constants for the GPU frame sequencer and the tile controller.
//   camera_t      : camera struct driven to the controller (pos + four look vectors)
//   ADDR_*        : Avalon-MM word addresses of the sequencer register map
//   CTRL_*/STAT_* : bit positions inside the CTRL and STATUS words
//   seq_state_t   : tile walker states
package gpu_pkg;

  localparam int CAM_FIELD_BITS = 16;
  localparam int CAM_FIELDS     = 15;
  localparam int CAM_BITS       = CAM_FIELDS * CAM_FIELD_BITS;

  typedef struct packed {
    logic signed [CAM_FIELD_BITS-1:0] x;
    logic signed [CAM_FIELD_BITS-1:0] y;
    logic signed [CAM_FIELD_BITS-1:0] z;
  } vec3_t;

  // Field order (MSB first) matches the register order: pos, look0..look3.
  typedef struct packed {
    vec3_t pos;
    vec3_t look0;
    vec3_t look1;
    vec3_t look2;
    vec3_t look3;
  } camera_t;

  localparam logic [3:0] ADDR_CTRL       = 4'd0;
  localparam logic [3:0] ADDR_STATUS     = 4'd1;
  localparam logic [3:0] ADDR_PIXEL_BASE = 4'd2;
  localparam logic [3:0] ADDR_VOXEL_BUF  = 4'd3;
  localparam logic [3:0] ADDR_VOXEL_CNT  = 4'd4;
  localparam logic [3:0] ADDR_PAL_BUF    = 4'd5;
  localparam logic [3:0] ADDR_PAL_LEN    = 4'd6;
  localparam logic [3:0] ADDR_TILE_IDX   = 4'd7;
  // Words 8..15 hold the camera, two fields per word.

  // CTRL write bits
  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  // CTRL read bits
  localparam int CTRL_RD_BUSY    = 0;
  localparam int CTRL_RD_IRQ_EN  = 1;
  localparam int CTRL_RD_DONE    = 2;
  // STATUS bits (read and write-1-to-clear)
  localparam int STAT_DONE_BIT   = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_ACK,
    ST_DRAIN,
    ST_DONE
  } seq_state_t;

endpackage

// File: rtl/gpu_csr_regs.sv
// Avalon-MM slave register file for the frame sequencer.
//   clock, reset_n            : clock / async active-low reset
//   s1_*                      : Avalon-MM slave (no waitrequest, 1-cycle read latency)
//   busy                      : frame in progress; freezes config and camera words
//   tile_idx                  : current tile index, read back at TILE_IDX
//   done_set                  : one-cycle frame-complete strobe from the tile walker
//   start                     : one-cycle start request (only issued while idle)
//   irq_en, done              : interrupt enable and sticky frame-done flag
//   pixel_base..palette_length: controller configuration words
//   cam                       : camera struct assembled from words 8..15
module gpu_csr_regs
  import gpu_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  s1_address,
  input  logic        s1_write,
  input  logic [31:0] s1_writedata,
  input  logic        s1_read,
  output logic [31:0] s1_readdata,
  input  logic        busy,
  input  logic [31:0] tile_idx,
  input  logic        done_set,
  output logic        start,
  output logic        irq_en,
  output logic        done,
  output logic [31:0] pixel_base,
  output logic [31:0] voxel_buffer,
  output logic [31:0] voxel_count,
  output logic [31:0] palette_buffer,
  output logic [31:0] palette_length,
  output camera_t     cam
);

  logic [31:0]         cam_word [0:7];
  logic [31:0]         rd_mux;
  logic [CAM_BITS-1:0] cam_bits;
  logic                cfg_write;
  logic                w1c_done;

  assign cfg_write = s1_write && !busy;
  assign start     = s1_write && (s1_address == ADDR_CTRL) &&
                     s1_writedata[CTRL_START_BIT] && !busy;
  assign w1c_done  = s1_write && (s1_address == ADDR_STATUS) &&
                     s1_writedata[STAT_DONE_BIT];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      irq_en         <= 1'b0;
      pixel_base     <= '0;
      voxel_buffer   <= '0;
      voxel_count    <= '0;
      palette_buffer <= '0;
      palette_length <= '0;
      // NOTE: the camera array is a handful of flops, not a RAM, so it is
      // reset like any other register and the controller never sees X.
      for (int i = 0; i < 8; i++) cam_word[i] <= '0;
    end else if (s1_write) begin
      case (s1_address)
        ADDR_CTRL:       irq_en <= s1_writedata[CTRL_IRQ_EN_BIT];
        ADDR_STATUS,
        ADDR_TILE_IDX:   ;
        ADDR_PIXEL_BASE: if (cfg_write) pixel_base     <= s1_writedata;
        ADDR_VOXEL_BUF:  if (cfg_write) voxel_buffer   <= s1_writedata;
        ADDR_VOXEL_CNT:  if (cfg_write) voxel_count    <= s1_writedata;
        ADDR_PAL_BUF:    if (cfg_write) palette_buffer <= s1_writedata;
        ADDR_PAL_LEN:    if (cfg_write) palette_length <= s1_writedata;
        default: begin
          // Camera words; the upper half of word 15 is reserved and held at 0.
          if (cfg_write) begin
            if (s1_address[2:0] == 3'd7)
              cam_word[7] <= {16'h0000, s1_writedata[15:0]};
            else
              cam_word[s1_address[2:0]] <= s1_writedata;
          end
        end
      endcase
    end
  end

  // Frame completion beats a same-cycle W1C so a finished frame is never lost.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                done <= 1'b0;
    else if (done_set)           done <= 1'b1;
    else if (start || w1c_done)  done <= 1'b0;
  end

  always_comb begin
    // NOTE: default first so no path through the case infers a latch.
    rd_mux = '0;
    case (s1_address)
      ADDR_CTRL: begin
        rd_mux[CTRL_RD_BUSY]   = busy;
        rd_mux[CTRL_RD_IRQ_EN] = irq_en;
        rd_mux[CTRL_RD_DONE]   = done;
      end
      ADDR_STATUS:     rd_mux[STAT_DONE_BIT] = done;
      ADDR_PIXEL_BASE: rd_mux = pixel_base;
      ADDR_VOXEL_BUF:  rd_mux = voxel_buffer;
      ADDR_VOXEL_CNT:  rd_mux = voxel_count;
      ADDR_PAL_BUF:    rd_mux = palette_buffer;
      ADDR_PAL_LEN:    rd_mux = palette_length;
      ADDR_TILE_IDX:   rd_mux = tile_idx;
      default:         rd_mux = cam_word[s1_address[2:0]];
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     s1_readdata <= '0;
    else if (s1_read) s1_readdata <= rd_mux;
  end

  // Field k lives in word k/2, low half for even k, high half for odd k.
  always_comb begin
    cam_bits = '0;
    for (int i = 0; i < CAM_FIELDS; i++)
      cam_bits[(CAM_FIELDS-1-i)*CAM_FIELD_BITS +: CAM_FIELD_BITS] =
        cam_word[i/2][(i%2)*CAM_FIELD_BITS +: CAM_FIELD_BITS];
  end

  assign cam = camera_t'(cam_bits);

endmodule

// File: rtl/gpu_frame_sequencer.sv
// Frame sequencer in front of the tile rasterizer/shader controller.
// Walks the frame tile by tile (row-major), pulsing do_render, waiting for the
// controller's level irq, acknowledging it with clear_interrupt and advancing
// the tile origin and per-tile pixel buffer pointer. Raises irq when done.
//   clock, reset_n           : clock / async active-low reset (shared with controller)
//   s1_*                     : Avalon-MM slave to the host CPU
//   cam, *_buffer, *_count,
//   palette_length           : controller configuration
//   start_row, start_col     : origin of the current tile
//   do_render                : one-cycle tile start pulse
//   clear_interrupt          : one-cycle tile acknowledge pulse
//   gpu_irq                  : controller tile-done (level)
//   irq                      : frame-done interrupt to the CPU
module gpu_frame_sequencer
  import gpu_pkg::*;
#(
  parameter int TOTAL_ROWS = 120,
  parameter int TOTAL_COLS = 160,
  parameter int TILE_ROWS  = 8,
  parameter int TILE_COLS  = 8,
  parameter int PIXEL_BITS = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [3:0]            s1_address,
  input  logic                  s1_write,
  input  logic [31:0]           s1_writedata,
  input  logic                  s1_read,
  output logic [31:0]           s1_readdata,
  output camera_t               cam,
  output logic [31:0]           pixel_buffer,
  output logic [31:0]           voxel_buffer,
  output logic [31:0]           voxel_count,
  output logic [31:0]           palette_buffer,
  output logic [31:0]           palette_length,
  output logic [PIXEL_BITS-1:0] start_row,
  output logic [PIXEL_BITS-1:0] start_col,
  output logic                  do_render,
  output logic                  clear_interrupt,
  input  logic                  gpu_irq,
  output logic                  irq
);

  localparam int NUM_TILES = (TOTAL_ROWS / TILE_ROWS) * (TOTAL_COLS / TILE_COLS);
  localparam int IDX_BITS  = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;

  localparam logic [IDX_BITS-1:0]   LAST_TILE   = IDX_BITS'(NUM_TILES - 1);
  localparam logic [31:0]           TILE_PIXELS = 32'(TILE_ROWS * TILE_COLS);
  // Column arithmetic carries one extra bit so TOTAL_COLS may equal 2**PIXEL_BITS.
  localparam logic [PIXEL_BITS:0]   COL_STEP    = (PIXEL_BITS+1)'(TILE_COLS);
  localparam logic [PIXEL_BITS:0]   COL_END     = (PIXEL_BITS+1)'(TOTAL_COLS);
  localparam logic [PIXEL_BITS-1:0] ROW_STEP    = PIXEL_BITS'(TILE_ROWS);

  seq_state_t          state;
  logic [IDX_BITS-1:0] tile_idx;
  logic [IDX_BITS-1:0] next_idx;
  logic [PIXEL_BITS:0] col_next;
  logic                busy;
  logic                start;
  logic                done;
  logic                done_set;
  logic                irq_en;
  logic [31:0]         pixel_base;

  assign busy     = (state != ST_IDLE);
  assign done_set = (state == ST_DONE);
  assign next_idx = tile_idx + IDX_BITS'(1);
  assign col_next = {1'b0, start_col} + COL_STEP;
  assign irq      = done & irq_en;

  gpu_csr_regs u_csr (
    .clock          (clock),
    .reset_n        (reset_n),
    .s1_address     (s1_address),
    .s1_write       (s1_write),
    .s1_writedata   (s1_writedata),
    .s1_read        (s1_read),
    .s1_readdata    (s1_readdata),
    .busy           (busy),
    .tile_idx       (32'(tile_idx)),
    .done_set       (done_set),
    .start          (start),
    .irq_en         (irq_en),
    .done           (done),
    .pixel_base     (pixel_base),
    .voxel_buffer   (voxel_buffer),
    .voxel_count    (voxel_count),
    .palette_buffer (palette_buffer),
    .palette_length (palette_length),
    .cam            (cam)
  );

  // do_render is raised on every entry to ISSUE and clear_interrupt on entry
  // to ACK, so each is high exactly while the FSM sits in that state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      tile_idx        <= '0;
      start_row       <= '0;
      start_col       <= '0;
      pixel_buffer    <= '0;
      do_render       <= 1'b0;
      clear_interrupt <= 1'b0;
    end else begin
      do_render       <= 1'b0;
      clear_interrupt <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state        <= ST_ISSUE;
            tile_idx     <= '0;
            start_row    <= '0;
            start_col    <= '0;
            pixel_buffer <= pixel_base;
            do_render    <= 1'b1;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (gpu_irq) begin
            state           <= ST_ACK;
            clear_interrupt <= 1'b1;
          end
        end
        ST_ACK: state <= ST_DRAIN;
        ST_DRAIN: begin
          // Wait for the controller to drop its irq before the next tile so
          // the stale level is not mistaken for the next tile's completion.
          if (!gpu_irq) begin
            if (tile_idx == LAST_TILE) begin
              state <= ST_DONE;
            end else begin
              state        <= ST_ISSUE;
              tile_idx     <= next_idx;
              pixel_buffer <= pixel_base + (32'(next_idx) * TILE_PIXELS);
              do_render    <= 1'b1;
              if (col_next == COL_END) begin
                start_col <= '0;
                start_row <= start_row + ROW_STEP;
              end else begin
                start_col <= col_next[PIXEL_BITS-1:0];
              end
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_frame_sequencer.sv
module tb_gpu_frame_sequencer;
  import gpu_pkg::*;

  localparam int TR  = 16;
  localparam int TC  = 16;
  localparam int TLR = 8;
  localparam int TLC = 8;
  localparam int N_TILES   = (TR / TLR) * (TC / TLC);
  localparam int COL_TILES = TC / TLC;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  s1_address;
  logic        s1_write;
  logic [31:0] s1_writedata;
  logic        s1_read;
  logic [31:0] s1_readdata;
  camera_t     cam;
  logic [31:0] pixel_buffer, voxel_buffer, voxel_count, palette_buffer, palette_length;
  logic [7:0]  start_row, start_col;
  logic        do_render, clear_interrupt, gpu_irq, irq;

  gpu_frame_sequencer #(
    .TOTAL_ROWS (TR),
    .TOTAL_COLS (TC),
    .TILE_ROWS  (TLR),
    .TILE_COLS  (TLC),
    .PIXEL_BITS (8)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .s1_address      (s1_address),
    .s1_write        (s1_write),
    .s1_writedata    (s1_writedata),
    .s1_read         (s1_read),
    .s1_readdata     (s1_readdata),
    .cam             (cam),
    .pixel_buffer    (pixel_buffer),
    .voxel_buffer    (voxel_buffer),
    .voxel_count     (voxel_count),
    .palette_buffer  (palette_buffer),
    .palette_length  (palette_length),
    .start_row       (start_row),
    .start_col       (start_col),
    .do_render       (do_render),
    .clear_interrupt (clear_interrupt),
    .gpu_irq         (gpu_irq),
    .irq             (irq)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { string name; logic [31:0] val; } rd_exp_t;
  typedef struct { int row; int col; logic [31:0] pbuf; } tile_exp_t;

  rd_exp_t     exp_rd[$];
  tile_exp_t   exp_tile[$];
  logic [31:0] m_reg [16];
  bit          m_irq_en, m_done, m_run;
  int          m_tile;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_reg[i] = '0;
    m_irq_en = 0; m_done = 0; m_run = 0; m_tile = 0;
  endfunction

  function automatic void model_frame_done();
    m_done = 1; m_run = 0; m_tile = N_TILES - 1;
  endfunction

  function automatic logic [31:0] exp_read(input logic [3:0] a);
    case (a)
      4'd0:    return {29'd0, m_done, m_irq_en, m_run};
      4'd1:    return {31'd0, m_done};
      4'd7:    return 32'(m_tile);
      default: return m_reg[a];
    endcase
  endfunction

  function automatic void model_write(input logic [3:0] a, input logic [31:0] d);
    tile_exp_t t;
    case (a)
      4'd0: begin
        m_irq_en = d[1];
        if (d[0] && !m_run) begin
          m_run = 1; m_done = 0; m_tile = 0;
          for (int k = 0; k < N_TILES; k++) begin
            t.row  = (k / COL_TILES) * TLR;
            t.col  = (k % COL_TILES) * TLC;
            t.pbuf = m_reg[2] + 32'(k * TLR * TLC);
            exp_tile.push_back(t);
          end
        end
      end
      4'd1: if (d[0]) m_done = 0;
      4'd7: ;
      default: if (!m_run) m_reg[a] = (a == 4'd15) ? {16'h0, d[15:0]} : d;
    endcase
  endfunction

  // ---------------- bus driver ----------------
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    s1_address = a; s1_writedata = d; s1_write = 1'b1;
    @(posedge clock); #1;
    s1_write = 1'b0;
    model_write(a, d);
  endtask

  task automatic bus_read(input logic [3:0] a);
    rd_exp_t e;
    e.name = $sformatf("read_w%0d", a);
    e.val  = exp_read(a);
    exp_rd.push_back(e);
    s1_address = a; s1_read = 1'b1;
    @(posedge clock); #1;
    s1_read = 1'b0;
  endtask

  // ---------------- monitor ----------------
  logic rd_q;
  int   dr_cnt  = 0;
  int   clr_cnt = 0;

  always @(posedge clock or negedge reset_n)
    if (!reset_n) rd_q <= 1'b0;
    else          rd_q <= s1_read;

  always @(negedge clock) begin : monitor
    rd_exp_t   r;
    tile_exp_t t;
    if (reset_n) begin
      if (rd_q) begin
        if (exp_rd.size() == 0) check("unexpected_read", 32'd1, 32'd0);
        else begin r = exp_rd.pop_front(); check(r.name, s1_readdata, r.val); end
      end
      if (do_render) begin
        dr_cnt++;
        if (exp_tile.size() == 0) check("unexpected_do_render", 32'd1, 32'd0);
        else begin
          t = exp_tile.pop_front();
          check("tile_row",  32'(start_row), 32'(t.row));
          check("tile_col",  32'(start_col), 32'(t.col));
          check("tile_pbuf", pixel_buffer,   t.pbuf);
        end
      end
      if (clear_interrupt) clr_cnt++;
    end
  end

  // ---------------- controller model ----------------
  int drop_max = 3;

  initial begin : controller
    int ph;
    int cnt;
    ph = 0; cnt = 0; gpu_irq = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        gpu_irq = 1'b0; ph = 0;
      end else begin
        case (ph)
          0: if (do_render) begin cnt = $urandom_range(2, 8); ph = 1; end
          1: if (cnt <= 1) begin gpu_irq = 1'b1; ph = 2; end else cnt--;
          2: if (clear_interrupt) begin
               cnt = (drop_max == 0) ? 0 : $urandom_range(0, drop_max);
               ph = 3;
             end
          3: if (cnt == 0) begin gpu_irq = 1'b0; ph = 0; end else cnt--;
          default: ph = 0;
        endcase
      end
    end
  end

  task automatic wait_frame(input string tag, input int d0, input int c0);
    for (int i = 0; i < 3000 && !irq; i++) @(negedge clock);
    check({tag, "_irq"},     32'(irq),         32'd1);
    check({tag, "_renders"}, 32'(dr_cnt - d0),  32'(N_TILES));
    check({tag, "_acks"},    32'(clr_cnt - c0), 32'(N_TILES));
    @(posedge clock); #1;
    model_frame_done();
  endtask

  // ---------------- main sequence ----------------
  initial begin : driver
    int d0, c0, n;
    reset_n = 1'b0; s1_address = '0; s1_write = 0; s1_writedata = '0; s1_read = 0;
    model_reset();
    repeat (3) @(posedge clock); #1;
    check("rst_do_render", 32'(do_render),       32'd0);
    check("rst_clear_int", 32'(clear_interrupt), 32'd0);
    check("rst_irq",       32'(irq),             32'd0);
    check("rst_start_row", 32'(start_row),       32'd0);
    check("rst_start_col", 32'(start_col),       32'd0);
    check("rst_pixel_buf", pixel_buffer,         32'd0);
    check("rst_readdata",  s1_readdata,          32'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;
    for (int a = 0; a < 16; a++) bus_read(4'(a));
    check("idle_irq", 32'(irq), 32'd0);

    // Basic programming and camera packing
    bus_write(4'd2, 32'h0000_1000);
    bus_write(4'd8, 32'h0002_0001);
    bus_read(4'd2);
    bus_read(4'd8);
    check("cam_pos_x", 32'(cam.pos.x), 32'd1);
    check("cam_pos_y", 32'(cam.pos.y), 32'd2);

    // Random config and camera words, including the reserved half of word 15
    for (int a = 3; a < 16; a++)
      if (a != 7 && a != 8) bus_write(4'(a), $urandom);
    for (int a = 2; a < 16; a++) bus_read(4'(a));
    check("cam_look0_x", {16'h0, cam.look0.x}, {16'h0, m_reg[9][31:16]});
    check("cam_look3_z", {16'h0, cam.look3.z}, {16'h0, m_reg[15][15:0]});

    // Frame 1: normal run, writes and restart while busy are dropped
    drop_max = 3;
    d0 = dr_cnt; c0 = clr_cnt;
    bus_write(4'd0, 32'h3);
    repeat (2) @(posedge clock); #1;
    bus_write(4'd4, 32'd99);
    bus_write(4'd9, 32'hDEAD_BEEF);
    bus_write(4'd0, 32'h3);
    bus_read(4'd4);
    wait_frame("frame1", d0, c0);
    bus_read(4'd0);
    bus_read(4'd1);
    bus_read(4'd4);
    bus_read(4'd7);
    bus_read(4'd9);
    bus_write(4'd1, 32'h1);
    check("w1c_irq_low", 32'(irq), 32'd0);
    bus_read(4'd1);

    // Frame 2: pointer wraps past 2^32; W1C lands on the completion cycle
    bus_write(4'd2, 32'hFFFF_FFA0);
    drop_max = 0;
    bus_write(4'd0, 32'h3);
    n = 0;
    for (int i = 0; i < 3000 && n < N_TILES; i++) begin
      @(negedge clock);
      if (clear_interrupt) n++;
    end
    check("frame2_acks", 32'(n), 32'(N_TILES));
    @(posedge clock);
    @(posedge clock); #1;
    bus_write(4'd1, 32'h1);
    model_frame_done();
    check("set_wins_irq", 32'(irq), 32'd1);
    bus_read(4'd1);
    bus_read(4'd7);
    bus_write(4'd1, 32'h1);
    check("w1c2_irq_low", 32'(irq), 32'd0);
    bus_read(4'd1);

    // Frame 3: reset while waiting on tile 2, then a fresh frame
    drop_max = 2;
    bus_write(4'd2, 32'h0000_0400);
    bus_write(4'd0, 32'h3);
    n = 0;
    for (int i = 0; i < 3000 && n < 3; i++) begin
      @(negedge clock);
      if (do_render) n++;
    end
    check("frame3_renders_before_rst", 32'(n), 32'd3);
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    check("midrst_do_render", 32'(do_render),       32'd0);
    check("midrst_clear_int", 32'(clear_interrupt), 32'd0);
    check("midrst_start_row", 32'(start_row),       32'd0);
    check("midrst_start_col", 32'(start_col),       32'd0);
    check("midrst_pixel_buf", pixel_buffer,         32'd0);
    check("midrst_irq",       32'(irq),             32'd0);
    exp_tile.delete();
    model_reset();
    repeat (2) @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    bus_read(4'd0);
    bus_read(4'd2);
    bus_read(4'd7);
    bus_write(4'd2, 32'h0000_2000);
    d0 = dr_cnt; c0 = clr_cnt;
    bus_write(4'd0, 32'h3);
    wait_frame("frame4", d0, c0);
    bus_read(4'd1);

    repeat (3) @(posedge clock); #1;
    check("tiles_left", 32'(exp_tile.size()), 32'd0);
    check("reads_left", 32'(exp_rd.size()),   32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
